// File: rtl/mem_responder.sv
// Memory-side responder for the MMU port: 64-bit RAM with a fixed-latency read
// pipeline, write-once-per-request commits, range/misalign flags and a write counter.
module mem_responder #(
   parameter int unsigned DEPTH        = 4096,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] mem_read_addr,
   input  logic [63:0] mem_data,
   input  logic        mem_write_signal,
   output logic [63:0] data_from_mem,
   output logic        access_fault,
   output logic        misaligned,
   output logic [31:0] wr_count
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [63:0]   mem_q [DEPTH];
   logic          last_we_q;
   logic [63:0]   last_addr_q;
   logic [63:0]   last_data_q;
   logic [31:0]   wr_count_q;
   logic [63:0]   data_q  [READ_LATENCY];
   logic          fault_q [READ_LATENCY];
   logic          mis_q   [READ_LATENCY];
   logic [63:0]   data_d  [READ_LATENCY];

   logic [AW-1:0] idx_s;
   logic          in_range_s;
   logic          commit_s;
   logic [63:0]   rd_word_s;

   assign idx_s      = mem_read_addr[AW+2:3];
   assign in_range_s = (mem_read_addr < (64'(DEPTH) << 3));
   // A commit edge that coincides with rst is dropped, hence the rst term.
   assign commit_s   = mem_write_signal && in_range_s && !rst &&
                       (!last_we_q || (mem_read_addr != last_addr_q) || (mem_data != last_data_q));

   always_comb begin
      rd_word_s = 64'd0;
      if (!in_range_s) begin
         rd_word_s = 64'd0;
      end else if (commit_s) begin
         rd_word_s = mem_data;
      end else begin
         rd_word_s = mem_q[idx_s];
      end
   end

   always_ff @(posedge clk) begin
      if (commit_s) begin
         mem_q[idx_s] <= mem_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_we_q   <= 1'b0;
         last_addr_q <= 64'd0;
         last_data_q <= 64'd0;
         wr_count_q  <= 32'd0;
      end else begin
         last_we_q   <= mem_write_signal;
         last_addr_q <= mem_read_addr;
         last_data_q <= mem_data;
         if (commit_s) begin
            wr_count_q <= wr_count_q + 32'd1;
         end
      end
   end

   // In-flight reads to a word committed this cycle pick up the new data as they advance.
   if (READ_LATENCY == 1) begin : g_single
      always_comb begin
         data_d[0] = rd_word_s;
      end
   end else begin : g_fwd
      logic [AW-1:0] idx_q [READ_LATENCY-1];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < READ_LATENCY - 1; i++) begin
               idx_q[i] <= '0;
            end
         end else begin
            idx_q[0] <= idx_s;
            for (int i = 1; i < READ_LATENCY - 1; i++) begin
               idx_q[i] <= idx_q[i-1];
            end
         end
      end

      always_comb begin
         data_d[0] = rd_word_s;
         for (int i = 1; i < READ_LATENCY; i++) begin
            if (commit_s && !fault_q[i-1] && (idx_q[i-1] == idx_s)) begin
               data_d[i] = mem_data;
            end else begin
               data_d[i] = data_q[i-1];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            data_q[i]  <= 64'd0;
            fault_q[i] <= 1'b0;
            mis_q[i]   <= 1'b0;
         end
      end else begin
         fault_q[0] <= !in_range_s;
         mis_q[0]   <= (mem_read_addr[2:0] != 3'd0);
         for (int i = 0; i < READ_LATENCY; i++) begin
            data_q[i] <= data_d[i];
         end
         for (int i = 1; i < READ_LATENCY; i++) begin
            fault_q[i] <= fault_q[i-1];
            mis_q[i]   <= mis_q[i-1];
         end
      end
   end

   assign data_from_mem = data_q[READ_LATENCY-1];
   assign access_fault  = fault_q[READ_LATENCY-1];
   assign misaligned    = mis_q[READ_LATENCY-1];
   assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a latency-1 and a latency-3 instance share stimulus.
module tb_mem_responder;
   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic        we;
   logic [63:0] d1, d3;
   logic        f1, f3, m1, m3;
   logic [31:0] c1, c3;

   always #5 clk = ~clk;

   mem_responder #(.DEPTH(4096), .READ_LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .mem_read_addr(addr), .mem_data(wdata),
      .mem_write_signal(we), .data_from_mem(d1), .access_fault(f1),
      .misaligned(m1), .wr_count(c1)
   );

   mem_responder #(.DEPTH(4096), .READ_LATENCY(3)) dut3 (
      .clk(clk), .rst(rst), .mem_read_addr(addr), .mem_data(wdata),
      .mem_write_signal(we), .data_from_mem(d3), .access_fault(f3),
      .misaligned(m3), .wr_count(c3)
   );

   typedef struct {
      logic [63:0] addr;
      logic [63:0] data;
      logic        we;
      logic [63:0] exp_d;
      logic        exp_f;
      logic        exp_m;
      logic [31:0] exp_c;
   } vec_t;

   vec_t vecs [23];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [63:0] a, input logic [63:0] d, input logic w);
      addr  = a;
      wdata = d;
      we    = w;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{64'h80,   64'h0000_0000_2000_0401, 1'b1, 64'h0000_0000_2000_0401, 1'b0, 1'b0, 32'd1};
      vecs[1]  = '{64'h80,   64'h0,                   1'b0, 64'h0000_0000_2000_0401, 1'b0, 1'b0, 32'd1};
      vecs[2]  = '{64'h100,  64'hDEAD_BEEF_0000_0001, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0, 32'd2};
      vecs[3]  = '{64'h100,  64'hDEAD_BEEF_0000_0001, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0, 32'd2};
      vecs[4]  = '{64'h100,  64'hDEAD_BEEF_0000_0001, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0, 32'd2};
      vecs[5]  = '{64'h100,  64'hDEAD_BEEF_0000_0001, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0, 32'd2};
      vecs[6]  = '{64'h100,  64'h0,                   1'b0, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0, 32'd2};
      vecs[7]  = '{64'h8000, 64'h1234,                1'b1, 64'h0,                   1'b1, 1'b0, 32'd2};
      vecs[8]  = '{64'h8000, 64'h0,                   1'b0, 64'h0,                   1'b1, 1'b0, 32'd2};
      vecs[9]  = '{64'h7FF8, 64'hA5,                  1'b1, 64'hA5,                  1'b0, 1'b0, 32'd3};
      vecs[10] = '{64'h7FF8, 64'h0,                   1'b0, 64'hA5,                  1'b0, 1'b0, 32'd3};
      vecs[11] = '{64'h0,    64'h11,                  1'b1, 64'h11,                  1'b0, 1'b0, 32'd4};
      vecs[12] = '{64'h8,    64'h22,                  1'b1, 64'h22,                  1'b0, 1'b0, 32'd5};
      vecs[13] = '{64'h10,   64'h33,                  1'b1, 64'h33,                  1'b0, 1'b0, 32'd6};
      vecs[14] = '{64'h0,    64'h0,                   1'b0, 64'h11,                  1'b0, 1'b0, 32'd6};
      vecs[15] = '{64'h9,    64'h0,                   1'b0, 64'h22,                  1'b0, 1'b1, 32'd6};
      vecs[16] = '{64'h10,   64'h0,                   1'b0, 64'h33,                  1'b0, 1'b0, 32'd6};
      vecs[17] = '{64'h10,   64'h44,                  1'b1, 64'h44,                  1'b0, 1'b0, 32'd7};
      vecs[18] = '{64'h10,   64'h44,                  1'b1, 64'h44,                  1'b0, 1'b0, 32'd7};
      vecs[19] = '{64'h10,   64'h0,                   1'b0, 64'h44,                  1'b0, 1'b0, 32'd7};
      vecs[20] = '{64'h10,   64'h44,                  1'b1, 64'h44,                  1'b0, 1'b0, 32'd8};
      vecs[21] = '{64'h84,   64'h77,                  1'b1, 64'h77,                  1'b0, 1'b1, 32'd9};
      vecs[22] = '{64'h80,   64'h0,                   1'b0, 64'h77,                  1'b0, 1'b0, 32'd9};

      rst = 1'b1;
      drive(64'h0, 64'h0, 1'b0);
      #3;
      chk("reset_data1", d1, 64'h0);
      chk("reset_fault1", 64'(f1), 64'h0);
      chk("reset_mis1", 64'(m1), 64'h0);
      chk("reset_cnt1", 64'(c1), 64'h0);
      chk("reset_data3", d3, 64'h0);
      step;
      step;
      rst = 1'b0;

      for (int i = 0; i < 23; i++) begin
         drive(vecs[i].addr, vecs[i].data, vecs[i].we);
         step;
         chk($sformatf("vec%0d_data", i), d1, vecs[i].exp_d);
         chk($sformatf("vec%0d_fault", i), 64'(f1), 64'(vecs[i].exp_f));
         chk($sformatf("vec%0d_mis", i), 64'(m1), 64'(vecs[i].exp_m));
         chk($sformatf("vec%0d_cnt1", i), 64'(c1), 64'(vecs[i].exp_c));
         chk($sformatf("vec%0d_cnt3", i), 64'(c3), 64'(vecs[i].exp_c));
      end

      // Back-to-back stream through the latency-3 pipeline.
      drive(64'h0, 64'h0, 1'b0);  step;
      drive(64'h9, 64'h0, 1'b0);  step;
      drive(64'h10, 64'h0, 1'b0); step;
      chk("l1_stream_data", d1, 64'h44);
      chk("l3_stream0_data", d3, 64'h11);
      chk("l3_stream0_mis", 64'(m3), 64'h0);
      drive(64'h80, 64'h0, 1'b0); step;
      chk("l3_stream1_data", d3, 64'h22);
      chk("l3_stream1_mis", 64'(m3), 64'h1);
      step;
      chk("l3_stream2_data", d3, 64'h44);
      chk("l3_stream2_mis", 64'(m3), 64'h0);

      // Commit to a word while a latency-3 read of it is in flight.
      drive(64'h200, 64'h1, 1'b1);  step;
      chk("fwd_pre_cnt", 64'(c1), 64'd10);
      drive(64'h200, 64'h0, 1'b0);  step;
      chk("fwd_read_l1", d1, 64'h1);
      drive(64'h200, 64'h55, 1'b1); step;
      chk("fwd_wfirst_l1", d1, 64'h55);
      chk("fwd_cnt3", 64'(c3), 64'd11);
      drive(64'h8, 64'h0, 1'b0);    step;
      chk("fwd_l3_data", d3, 64'h55);
      chk("fwd_l3_fault", 64'(f3), 64'h0);
      chk("fwd_after_l1", d1, 64'h22);

      // Asynchronous reset with a write held and reads in flight.
      drive(64'h300, 64'h99, 1'b1); step;
      chk("rst_pre_data", d1, 64'h99);
      chk("rst_pre_cnt", 64'(c1), 64'd12);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_mid_data1", d1, 64'h0);
      chk("rst_mid_data3", d3, 64'h0);
      chk("rst_mid_cnt", 64'(c1), 64'h0);
      step;
      chk("rst_hold_cnt", 64'(c1), 64'h0);
      chk("rst_hold_data", d1, 64'h0);
      rst = 1'b0;
      step;
      chk("rst_rel_cnt1", 64'(c1), 64'd1);
      chk("rst_rel_cnt3", 64'(c3), 64'd1);
      chk("rst_rel_data", d1, 64'h99);
      step;
      chk("rst_held_cnt", 64'(c1), 64'd1);
      drive(64'h300, 64'h0, 1'b0);  step;
      chk("rst_readback", d1, 64'h99);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
